dsp_bcin_mac: RTL

DSP_BCIN_MAC -- requirements
Module: dsp_bcin_mac

---
 rtl/dsp_bcin_mac.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/dsp_bcin_mac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dsp_bcin_mac
//  Purpose  : Cascaded-operand multiply-accumulate slice. The operand pair
//             (bcin, a) passes through BREG register stages, is multiplied
//             (unsigned 18x18), passes through MREG stages and is then
//             accumulated over ACC_LEN samples. A frame is seeded with 0 or
//             with pcin. The finished result is held until the consumer
//             takes it.
//  Ports    : clk, rst_n            clock, asynchronous active-low reset
//             bcin[17:0], a[17:0]   operands (bcin comes from upstream bcout)
//             in_valid / in_ready   input handshake
//             pcin[47:0], use_pcin  frame seed, sampled on the first accept
//             clr                   synchronous frame abort
//             bcout[17:0]           bcin after BREG stages
//             m[35:0]               product after MREG stages
//             p[47:0], p_valid      frame result and its valid flag
//             p_ready               consumer takes p
//             carryout              sticky carry out of bit 47 for this frame
//  Revision : 1.0  initial release
// ============================================================================
module dsp_bcin_mac #(
  parameter int BREG    = 1,
  parameter int MREG    = 1,
  parameter int ACC_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] bcin,
  input  logic [17:0] a,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] pcin,
  input  logic        use_pcin,
  input  logic        clr,
  output logic [17:0] bcout,
  output logic [35:0] m,
  output logic [47:0] p,
  output logic        p_valid,
  input  logic        p_ready,
  output logic        carryout
);

  localparam logic [7:0] LEN = 8'(ACC_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  acc_cnt;   // samples accepted in this frame
  logic [7:0]  add_cnt;   // products already folded into p
  logic        accept;
  logic [17:0] a_d;       // a, delayed to stay aligned with bcout
  logic        v_b;       // valid alongside bcout / a_d
  logic        v_m;       // valid alongside m: a product lands this edge
  logic [35:0] prod;
  logic [47:0] seed;
  logic [47:0] base;
  logic [48:0] sum;

  assign in_ready = (state == S_IDLE) || ((state == S_ACC) && (acc_cnt < LEN));
  // clr discards any sample presented in the same cycle
  assign accept   = in_valid && in_ready && !clr;

  // ---------------- operand (B) pipeline ----------------
  generate
    if (BREG == 0) begin : g_breg_comb
      assign bcout = bcin;
      assign a_d   = a;
      assign v_b   = accept;
    end else begin : g_breg_reg
      logic [17:0]     b_sr [BREG];
      logic [17:0]     a_sr [BREG];
      logic [BREG-1:0] v_sr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < BREG; i++) begin
            b_sr[i] <= '0;
            a_sr[i] <= '0;
          end
          v_sr <= '0;
        end else begin
          b_sr[0] <= bcin;
          a_sr[0] <= a;
          for (int i = 1; i < BREG; i++) begin
            b_sr[i] <= b_sr[i-1];
            a_sr[i] <= a_sr[i-1];
          end
          // data keeps flowing on clr, only the valid bits are flushed
          v_sr <= clr ? '0 : ((v_sr << 1) | BREG'(accept));
        end
      end

      assign bcout = b_sr[BREG-1];
      assign a_d   = a_sr[BREG-1];
      assign v_b   = v_sr[BREG-1];
    end
  endgenerate

  assign prod = 36'(a_d) * 36'(bcout);

  // ---------------- multiplier (M) pipeline ----------------
  generate
    if (MREG == 0) begin : g_mreg_comb
      assign m   = prod;
      assign v_m = v_b;
    end else begin : g_mreg_reg
      logic [35:0] m_r;
      logic        v_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          m_r <= '0;
          v_r <= 1'b0;
        end else begin
          m_r <= prod;
          v_r <= clr ? 1'b0 : v_b;
        end
      end

      assign m   = m_r;
      assign v_m = v_r;
    end
  endgenerate

  // ---------------- accumulator ----------------
  // In IDLE the adder base is the new seed, so with zero pipeline latency the
  // first product is folded in on the accepting edge itself.
  assign seed = use_pcin ? pcin : 48'd0;
  assign base = (state == S_IDLE) ? seed : p;
  assign sum  = {1'b0, base} + {13'd0, m};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      p        <= '0;
      p_valid  <= 1'b0;
      carryout <= 1'b0;
      acc_cnt  <= '0;
      add_cnt  <= '0;
    end else if (clr) begin
      state    <= S_IDLE;
      p        <= '0;
      p_valid  <= 1'b0;
      carryout <= 1'b0;
      acc_cnt  <= '0;
      add_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc_cnt <= 8'd1;
            if (v_m) begin
              p        <= sum[47:0];
              carryout <= sum[48];
              add_cnt  <= 8'd1;
              if (LEN == 8'd1) begin
                state   <= S_HOLD;
                p_valid <= 1'b1;
              end else begin
                state   <= S_ACC;
              end
            end else begin
              p        <= seed;
              carryout <= 1'b0;
              add_cnt  <= '0;
              state    <= S_ACC;
            end
          end
        end
        S_ACC: begin
          if (accept) acc_cnt <= acc_cnt + 8'd1;
          if (v_m) begin
            p        <= sum[47:0];
            carryout <= carryout | sum[48];
            add_cnt  <= add_cnt + 8'd1;
            if (add_cnt + 8'd1 == LEN) begin
              state   <= S_HOLD;
              p_valid <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (p_ready) begin
            state   <= S_IDLE;
            p_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
